// File: rtl/osd_pkg.sv
// Shared types, default geometry and a constant-width helper for the OSD text window.
package osd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOFS,
    ST_PREFETCH,
    ST_ACTIVE,
    ST_SKIP,
    ST_DONE
  } osd_state_t;

  localparam int DEF_TILE_W      = 6;
  localparam int DEF_TILE_H      = 8;
  localparam int DEF_WINDOW_W    = 32;
  localparam int DEF_WINDOW_H    = 8;
  localparam int DEF_LINE_REPEAT = 2;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_BLINK_LOG2  = 5;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/osd_textbuf.sv
// Character buffer: simple dual-port RAM with registered, enabled read.
// A read of the address being written in the same cycle returns the old contents.
module osd_textbuf #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wren,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              rden,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        q
);

  logic [7:0] mem [0:(1 << ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wren) mem[waddr] <= wdata;
    if (rden) q <= mem[raddr];
  end

endmodule

// File: rtl/osd_textwindow.sv
// OSD text window: line/frame sequencer, glyph fetch pipeline and pixel shifter.
// Valid/ready is not used here; all state advances on the ce pixel enable only.
module osd_textwindow
  import osd_pkg::*;
#(
  parameter int TILE_W      = DEF_TILE_W,
  parameter int TILE_H      = DEF_TILE_H,
  parameter int WINDOW_W    = DEF_WINDOW_W,
  parameter int WINDOW_H    = DEF_WINDOW_H,
  parameter int LINE_REPEAT = DEF_LINE_REPEAT,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int BLINK_LOG2  = DEF_BLINK_LOG2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic                      hsync,
  input  logic                      vsync,
  input  logic [9:0]                x_ofs,
  input  logic [9:0]                y_ofs,
  input  logic [ADDR_W-1:0]         address,
  input  logic [7:0]                data,
  input  logic                      wren,
  input  logic [ADDR_W-1:0]         cursor_addr,
  input  logic                      cursor_en,
  output logic [6+clog2(TILE_H):0]  chargen_addr,
  input  logic [TILE_W-1:0]         chargen_q,
  output logic                      pixel,
  output logic                      background
);

  localparam int TYW = clog2(TILE_H);
  localparam int PXW = clog2(TILE_W);
  localparam int CW  = clog2(WINDOW_W + 1);
  localparam int RW  = clog2(WINDOW_H + 1);
  localparam int RPW = clog2(LINE_REPEAT + 1);

  osd_state_t        state_q, state_d, line_first;
  logic [9:0]        hcount_q, hcount_d, scan_q, scan_d;
  logic [PXW-1:0]    px_q, px_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RPW-1:0]    rep_q, rep_d, adv_rep;
  logic [TYW-1:0]    ty_q, ty_d, adv_ty;
  logic [RW-1:0]     row_q, row_d, adv_row;
  logic [ADDR_W-1:0] base_q, base_d, adv_base;
  logic [BLINK_LOG2-1:0] blink_q, blink_d;
  logic              framed_q, framed_d;
  logic [TILE_W-1:0] shreg_q, shreg_d, glyph_row;
  logic [ADDR_W-1:0] fetch_addr_q, rd_addr;
  logic [7:0]        char_q;
  logic              hs_q, vs_q, hs_edge, vs_edge, rd_en, cursor_hit, adv_done;

  osd_textbuf #(.ADDR_W(ADDR_W)) u_textbuf (
    .clk   (clk),
    .wren  (wren),
    .waddr (address),
    .wdata (data),
    .rden  (rd_en),
    .raddr (rd_addr),
    .q     (char_q)
  );

  assign chargen_addr = {char_q[6:0], ty_q};

  always_comb begin
    hs_edge    = hs_q & ~hsync;
    vs_edge    = vs_q & ~vsync;
    rd_addr    = base_q + ADDR_W'(col_q);
    rd_en      = ce && (state_q == ST_PREFETCH || state_q == ST_ACTIVE) && (px_q == '0);
    cursor_hit = cursor_en & (fetch_addr_q == cursor_addr) & ~blink_q[BLINK_LOG2-1];
    glyph_row  = chargen_q ^ {TILE_W{char_q[7] ^ cursor_hit}};
    line_first = (x_ofs == '0) ? ST_PREFETCH : ST_HOFS;

    // Position after one completed scanline.
    adv_rep  = rep_q + 1'b1;
    adv_ty   = ty_q;
    adv_row  = row_q;
    adv_base = base_q;
    if (rep_q == RPW'(LINE_REPEAT - 1)) begin
      adv_rep = '0;
      adv_ty  = ty_q + 1'b1;
      if (ty_q == TYW'(TILE_H - 1)) begin
        adv_ty   = '0;
        adv_base = base_q + ADDR_W'(WINDOW_W);
        adv_row  = row_q + 1'b1;
      end
    end
    adv_done = (adv_row == RW'(WINDOW_H));

    state_d  = state_q;
    hcount_d = hcount_q;
    scan_d   = scan_q;
    px_d     = px_q;
    col_d    = col_q;
    rep_d    = rep_q;
    ty_d     = ty_q;
    row_d    = row_q;
    base_d   = base_q;
    blink_d  = blink_q;
    framed_d = framed_q;
    shreg_d  = shreg_q;

    if (vs_edge) begin
      state_d  = ST_IDLE;
      scan_d   = '0;
      rep_d    = '0;
      ty_d     = '0;
      row_d    = '0;
      base_d   = '0;
      blink_d  = blink_q + 1'b1;
      framed_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Lines are only started once a frame start has been seen since reset.
          if (hs_edge && framed_q) begin
            if (scan_q < y_ofs) begin
              scan_d = scan_q + 1'b1;
            end else begin
              state_d  = line_first;
              hcount_d = '0;
              px_d     = '0;
              col_d    = '0;
            end
          end
        end
        ST_DONE: ;
        default: begin
          if (hs_edge || state_q == ST_SKIP) begin
            rep_d  = adv_rep;
            ty_d   = adv_ty;
            row_d  = adv_row;
            base_d = adv_base;
            if (adv_done) begin
              state_d = ST_DONE;
            end else if (hs_edge) begin
              state_d  = line_first;
              hcount_d = '0;
              px_d     = '0;
              col_d    = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (state_q == ST_HOFS) begin
            if (hcount_q == x_ofs - 10'd1) begin
              state_d = ST_PREFETCH;
              px_d    = '0;
              col_d   = '0;
            end else begin
              hcount_d = hcount_q + 1'b1;
            end
          end else if (state_q == ST_PREFETCH || state_q == ST_ACTIVE) begin
            if (px_q == PXW'(TILE_W - 1)) begin
              px_d    = '0;
              col_d   = col_q + 1'b1;
              shreg_d = glyph_row;
              if (state_q == ST_PREFETCH) state_d = ST_ACTIVE;
              else if (col_q == CW'(WINDOW_W)) state_d = ST_SKIP;
            end else begin
              px_d = px_q + 1'b1;
              if (state_q == ST_ACTIVE) shreg_d = shreg_q << 1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hcount_q     <= '0;
      scan_q       <= '0;
      px_q         <= '0;
      col_q        <= '0;
      rep_q        <= '0;
      ty_q         <= '0;
      row_q        <= '0;
      base_q       <= '0;
      blink_q      <= '0;
      framed_q     <= 1'b0;
      shreg_q      <= '0;
      fetch_addr_q <= '0;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      pixel        <= 1'b0;
      background   <= 1'b0;
    end else if (ce) begin
      state_q    <= state_d;
      hcount_q   <= hcount_d;
      scan_q     <= scan_d;
      px_q       <= px_d;
      col_q      <= col_d;
      rep_q      <= rep_d;
      ty_q       <= ty_d;
      row_q      <= row_d;
      base_q     <= base_d;
      blink_q    <= blink_d;
      framed_q   <= framed_d;
      shreg_q    <= shreg_d;
      hs_q       <= hsync;
      vs_q       <= vsync;
      background <= (state_q == ST_ACTIVE);
      pixel      <= (state_q == ST_ACTIVE) & shreg_q[TILE_W-1];
      if (rd_en) fetch_addr_q <= rd_addr;
    end
  end

endmodule

// File: doc/osd_textwindow.md
# osd_textwindow

Parametrised on-screen-display text window, successor to the fixed 32x8 OSD text generator. It owns a dual-port character buffer, fetches glyph rows from an external synchronous character ROM, and serialises pixels, advancing on `ce`. Behaviour added over the fixed version:
- runtime X/Y window placement;
- configurable tile size, window size and scanline repeat;
- a blinking hardware cursor.

It sits between the CPU-side OSD writer and the video mixer.

## Interface
- `TILE_W`, 6: glyph width in pixels, 3..8.
- `TILE_H`, 8: glyph height in rows, 8 or 16.
- `WINDOW_W`, 32: text columns.
- `WINDOW_H`, 8: text rows.
- `LINE_REPEAT`, 2: scanlines per glyph row, 1..4.
- `ADDR_W`, 8: buffer address width; must satisfy 2^ADDR_W >= WINDOW_W*WINDOW_H.
- `BLINK_LOG2`, 5: cursor blink period is 2^BLINK_LOG2 frames.

Ports:
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `ce` in 1: pixel clock enable.
- `hsync` in 1: active-low; its falling edge (sampled on `ce`) starts a line.
- `vsync` in 1: active-low; its falling edge (sampled on `ce`) starts a frame.
- `x_ofs` in 10: pixels (`ce` cycles) from line start to the prefetch phase.
- `y_ofs` in 10: scanlines skipped after frame start.
- `address` in ADDR_W: buffer write address.
- `data` in 8: write data. Bit 7 = inverse video; bits 6:0 = glyph code.
- `wren` in 1: buffer write strobe; one write per `clk` with `wren` high, independent of `ce`.
- `cursor_addr` in ADDR_W: buffer address of the cursor.
- `cursor_en` in 1: cursor enable.
- `chargen_addr` out 7+log2(TILE_H): `{code, tile_y}` to the character ROM.
- `chargen_q` in TILE_W: ROM row data, valid one `clk` after `chargen_addr`; MSB is the leftmost pixel.
- `pixel` out 1: foreground pixel, already gated by `background`.
- `background` out 1: high while the window is being drawn.

## Operation
States: IDLE, HOFS, PREFETCH, ACTIVE, SKIP, DONE. All transitions happen on `ce` only; `reset` overrides all.
- **Reset:** state=IDLE; all counters=0; `pixel`=0; `background`=0; blink counter=0.
- **vsync edge:** state=IDLE, scanline=0, row=0, `tile_y`=0, repeat=0, `text_base`=0, blink counter +1. The vsync edge has priority over an hsync edge in the same `ce`; that hsync edge is not counted.
- **hsync edge in IDLE:**
  - scanline < `y_ofs`: scanline +1 and stay in IDLE.
  - otherwise: go to HOFS with hcount=0.
- **hsync edge in any other state except DONE:** aborts the current line. It counts as a completed line (vertical advance) and restarts in HOFS.
- **HOFS:** lasts `x_ofs` `ce` cycles, then PREFETCH. With `x_ofs`=0, HOFS is skipped.
- **PREFETCH:** lasts TILE_W `ce` cycles and loads column 0.
- **ACTIVE:** lasts TILE_W*WINDOW_W `ce` cycles, then SKIP.
- **Fetch for the next column, during each tile period:**
  - pixel 0: text address = `text_base` + `col`, mod 2^ADDR_W.
  - pixel 1: charcode is registered and `chargen_addr` is driven.
  - tile boundary: the `chargen_q` row is loaded into the shift register. If charcode[7] XOR cursor_hit, the row is inverted.
  - cursor_hit = `cursor_en` & (addr==`cursor_addr`) & ~blink[BLINK_LOG2-1].
- **Vertical advance (SKIP):** repeat +1.
  - At LINE_REPEAT: repeat=0 and `tile_y` +1.
  - At `tile_y`=TILE_H-1: `tile_y`=0, `text_base` += WINDOW_W, row +1.
  - At row=WINDOW_H: DONE; otherwise IDLE-wait for the next hsync edge.
- **DONE:** holds until vsync edge or `reset`.
- **Buffer read-during-write:** a read of the address being written in the same cycle returns the old data.

## Timing
- Let the `ce` cycle with the detected hsync edge be cycle 0.
- `background` is high exactly for cycles X_OFS+TILE_W+1 through X_OFS+TILE_W+TILE_W*WINDOW_W inclusive.
- Pixel p of column c appears at cycle X_OFS+TILE_W*(c+1)+p+1.
- Total output latency is one registered stage after the shift register.
- With `ce` asserted every `clk`, the RAM→ROM path meets its deadline by pixel TILE_W-1. This is why TILE_W ≥ 3.
- `pixel`=0 whenever `background`=0.

## Structure
- Package `osd_pkg`: state enum, default parameter constants, `clog2` helper.
- Sub-module `osd_textbuf`: simple dual-port RAM, 2^ADDR_W x 8, registered read, old-data on collision. Instantiated once.
- The counter/FSM and the pixel shifter stay in `osd_textwindow`.

## Test plan
- **Reset mid-line:** assert `reset` during ACTIVE → next cycle `background`=0 and `pixel`=0; no output until a vsync edge followed by an hsync edge.
- **Placement:** `x_ofs`=10, `y_ofs`=3, defaults → `background` rises at `ce` cycle 17 of the 4th scanline after vsync, lasts 192 cycles, and is absent on scanlines 0..2.
- **Glyph path:** write 0x41 at address 0, ROM row = 6'b101100 → first six pixels 1,0,1,1,0,0. Write 0xC1 → 0,1,0,0,1,1.
- **Cursor:** `cursor_en`=1, `cursor_addr`=33 → column 1 of text row 1 is inverted for 16 frames, then normal for 16 frames. 0xC1 under the cursor shows non-inverted while the cursor is visible.
- **Vertical geometry:** TILE_H=8, LINE_REPEAT=2, WINDOW_H=8 → exactly 128 drawn scanlines, then DONE; further hsync edges produce no `background`.
- **Collisions:**
  - vsync and hsync edges in the same `ce` → frame restart, with no line counted.
  - `wren` to the address being read → old data displayed on this line, new data on the next.
